uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 98 +++++++++
 tb/tb_uart_tx_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NREQ byte requesters.
// Sequences the tx_start / tx_ready handshake so each grant yields exactly one frame.
module uart_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int BUSY_TO = 16,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(BUSY_TO + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] din,
    output logic [NREQ-1:0]   ack,
    output logic [GW-1:0]     grant_id,
    output logic              busy,
    output logic              to_err,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_ready
);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state;
    logic [GW-1:0] last;
    logic [CW-1:0] cnt;
    logic          found;
    logic [GW-1:0] win;

    // Rotating priority: the search starts just after the last winner and wraps.
    always_comb begin
        // NOTE: defaults assigned up front so no path leaves found/win unassigned (no latch).
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(last) + k) % NREQ]) begin
                found = 1'b1;
                win   = GW'((int'(last) + k) % NREQ);
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            last     <= GW'(NREQ - 1);
            cnt      <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            to_err   <= 1'b0;
            grant_id <= '0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            to_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_ready && found) begin
                        tx_data  <= din[8*int'(win) +: 8];
                        ack[win] <= 1'b1;
                        tx_start <= 1'b1;
                        grant_id <= win;
                        last     <= win;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    // tx_ready never dropped: the byte is abandoned, not retried.
                    if (!tx_ready) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CW'(BUSY_TO - 1)) begin
                        to_err <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (tx_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed phases plus randomized traffic
// against a transaction-level reference model and a behavioural uart_tx ready mock.
module tb_uart_tx_arbiter;

    localparam int NREQ    = 3;
    localparam int BUSY_TO = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] din;
    logic              tx_ready;
    logic [NREQ-1:0]   ack;
    logic [1:0]        grant_id;
    logic              busy, to_err, tx_start;
    logic [7:0]        tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TO(BUSY_TO)) dut (
        .clk(clk), .rstn(rstn), .req(req), .din(din), .ack(ack),
        .grant_id(grant_id), .busy(busy), .to_err(to_err), .tx_data(tx_data),
        .tx_start(tx_start), .tx_ready(tx_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a grant opens a transfer stamped with its start cycle; the
    // transfer closes when ready returns after dropping, or BUSY_TO cycles after start.
    int              cyc = 0;
    int              m_last = NREQ - 1;
    bit              m_active = 0, m_low = 0;
    int              m_start = 0;
    logic [NREQ-1:0] e_ack = '0;
    logic            e_start = 0, e_busy = 0, e_to = 0;
    logic [7:0]      e_data = 8'h00;
    logic [1:0]      e_gid = '0;

    task automatic model_edge();
        int w;
        cyc++;
        e_ack   = '0;
        e_start = 0;
        e_to    = 0;
        if (!rstn) begin
            m_last = NREQ - 1; m_active = 0; e_data = 8'h00; e_gid = '0; e_busy = 0;
        end else if (!m_active) begin
            if (tx_ready && req != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                e_ack[w] = 1'b1;
                e_start  = 1;
                e_data   = din[8*w +: 8];
                e_gid    = 2'(w);
                m_last   = w;
                m_active = 1;
                m_low    = 0;
                m_start  = cyc;
                e_busy   = 1;
            end
        end else if (!m_low) begin
            if (!tx_ready) m_low = 1;
            else if (cyc == m_start + BUSY_TO) begin
                e_to = 1; m_active = 0; e_busy = 0;
            end
        end else if (tx_ready) begin
            m_active = 0; e_busy = 0;
        end
    endtask

    // uart_tx ready mock: drops mock_fall cycles after a start for mock_low cycles; never if mock_fall < 0.
    int  mock_t = -1, mock_fall = 2, mock_low = 20;
    bit  rand_mock = 0;
    int  ncyc = 0, t_start = -1, t_to = -1, t_ack = -1;
    int  grant_log[$];
    logic [7:0] data_log[$];
    int  ack_cnt[NREQ];

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        ncyc++;
        check("ack", 32'(ack), 32'(e_ack));
        check("tx_start", 32'(tx_start), 32'(e_start));
        check("tx_data", 32'(tx_data), 32'(e_data));
        check("grant_id", 32'(grant_id), 32'(e_gid));
        check("busy", 32'(busy), 32'(e_busy));
        check("to_err", 32'(to_err), 32'(e_to));
        if (ack != '0) begin
            grant_log.push_back(int'(grant_id));
            data_log.push_back(tx_data);
            for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(ack[i]);
            t_ack = ncyc;
        end
        if (tx_start) t_start = ncyc;
        if (to_err) t_to = ncyc;
        if (rand_mock && tx_start) begin
            mock_fall = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, BUSY_TO + 2));
            mock_low  = $urandom_range(0, 12);
        end
        if (!rstn) mock_t = -1;
        else if (tx_start) mock_t = 0;
        else if (mock_t >= 0) mock_t++;
        tx_ready = !(mock_t >= 0 && mock_fall >= 0 && mock_t >= mock_fall && mock_t < mock_fall + mock_low);
        if (mock_t >= 0 && (mock_fall < 0 || mock_t >= mock_fall + mock_low)) mock_t = -1;
    endtask

    task automatic wait_grants(input int n, input int budget);
        int b = 0;
        while (grant_log.size() < n && b < budget) begin step(); b++; end
        check("grants_seen", 32'(grant_log.size()), 32'(n));
    endtask

    task automatic wait_idle(input int budget);
        int b = 0;
        while (busy && b < budget) begin step(); b++; end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    initial begin
        int b, b1;
        logic [NREQ-1:0] acked_d;
        rstn = 1'b0; req = 3'b011; din = '0; tx_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;

        // Reset held for 3 cycles with requests pending: nothing may be granted.
        repeat (3) begin
            step();
            check("rst_ack", 32'(ack), 32'(0));
            check("rst_data", 32'(tx_data), 32'(0));
        end
        rstn = 1'b1;
        wait_grants(1, 10);
        check("first_grant_id", 32'(grant_log[0]), 32'(0));
        req = '0;
        wait_idle(80);

        // Single byte "A" with a well-behaved transmitter.
        grant_log.delete(); data_log.delete();
        req = 3'b001; din = 24'h000041;
        wait_grants(1, 20);
        req = '0;
        check("single_data", 32'(data_log[0]), 32'h41);
        step();
        check("single_ack_pulse", 32'(ack), 32'(0));
        wait_idle(60);

        // Two continuous requesters alternate; last winner was 0 so 1 goes first.
        grant_log.delete(); data_log.delete();
        req = 3'b011; din = 24'h004241;
        wait_grants(4, 200);
        req = '0;
        for (int k = 0; k < grant_log.size(); k++) begin
            check("rr_id", 32'(grant_log[k]), 32'((k + 1) % 2));
            check("rr_data", 32'(data_log[k]), 32'(8'h41 + 8'((k + 1) % 2)));
        end
        wait_idle(60);

        // Requester 1 idle: grants skip it; once it asserts after a grant to 0 it wins next.
        grant_log.delete(); data_log.delete();
        b1 = ack_cnt[1];
        req = 3'b101; din = 24'h430041;
        wait_grants(4, 200);
        for (int k = 0; k < grant_log.size(); k++)
            check("skip_id", 32'(grant_log[k]), 32'((k % 2 == 0) ? 2 : 0));
        check("skip_no_req1", 32'(ack_cnt[1] - b1), 32'(0));
        req = 3'b111; din = 24'h434241;
        wait_grants(5, 60);
        check("req1_next", 32'(grant_log[4]), 32'(1));
        check("req1_data", 32'(data_log[4]), 32'h42);
        req = '0;
        wait_idle(60);

        // Transmitter never drops ready: timeout after exactly BUSY_TO cycles, then regrant.
        grant_log.delete(); data_log.delete();
        mock_fall = -1; t_to = -1;
        req = 3'b001;
        wait_grants(1, 20);
        b = 0;
        while (t_to < 0 && b < 3 * BUSY_TO) begin step(); b++; end
        check("to_latency", 32'(t_to - t_start), 32'(BUSY_TO));
        wait_grants(2, 10);
        check("to_regrant_gap", 32'(t_ack - t_to), 32'(1));
        req = '0;
        wait_idle(3 * BUSY_TO);
        mock_fall = 2; mock_low = 20;

        // Reset while the frame is in flight, then lowest-index requester wins.
        grant_log.delete(); data_log.delete();
        req = 3'b001;
        b = 0;
        while (!(busy && !tx_ready) && b < 40) begin step(); b++; end
        step();
        rstn = 1'b0;
        step();
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_start", 32'(tx_start), 32'(0));
        rstn = 1'b1; req = 3'b011; din = 24'h004241;
        grant_log.delete();
        wait_grants(1, 40);
        check("midrst_first", 32'(grant_log[0]), 32'(0));
        req = '0;
        wait_idle(80);

        // Randomized traffic, transmitter behaviour and occasional resets.
        rand_mock = 1; acked_d = '0;
        for (int n = 0; n < 2000; n++) begin
            rstn = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && acked_d[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else din[8*i +: 8] = 8'($urandom);
                end else if (!req[i]) begin
                    if ($urandom_range(0, 9) < 3) begin
                        req[i] = 1'b1;
                        din[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
            acked_d = ack;
        end
        rstn = 1'b1; req = '0; rand_mock = 0; mock_fall = 2; mock_low = 20;
        wait_idle(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
